// File: rtl/adc_smoother_if.sv
// Event handshake between adc_smoother (master) and its consumer (slave).
// An event transfers on a rising edge where EventValid && EventReady; while EventValid is high and EventReady low, EventChannel/EventValue hold.
interface adc_smoother_if;
    logic        EventValid;
    logic [3:0]  EventChannel;
    logic [11:0] EventValue;
    logic        EventReady;

    modport master (output EventValid, output EventChannel, output EventValue, input EventReady);
    modport slave  (input EventValid, input EventChannel, input EventValue, output EventReady);
endinterface

// File: rtl/adc_smoother.sv
// Nine-channel EMA smoother: on Tick, snapshots the raw inputs, filters each channel in turn and emits change events.
// Define ADC_SMOOTH_HYST_EN to apply the DEADBAND threshold; otherwise any change of the filtered value is an event.
module adc_smoother #(
    parameter int SHIFT    = 3,
    parameter int DEADBAND = 8
) (
    input  logic                 Clock_qsys,
    input  logic                 Reset,
    input  logic [11:0]          AdcValue00,
    input  logic [11:0]          AdcValue01,
    input  logic [11:0]          AdcValue02,
    input  logic [11:0]          AdcValue03,
    input  logic [11:0]          AdcValue04,
    input  logic [11:0]          AdcValue05,
    input  logic [11:0]          AdcValue06,
    input  logic [11:0]          AdcValue07,
    input  logic [11:0]          AdcValue08,
    input  logic                 Tick,
    adc_smoother_if.master       eventBus,
    output logic                 Busy,
    output logic                 Overrun,
    output logic [2:0]           DebugState
);
    localparam int AW = 12 + SHIFT;

    typedef enum logic [2:0] {IDLE, LOAD, FILTER, COMPARE, EMIT} stateE;

    stateE         state, stateNext;
    logic [11:0]   rawIn [9];
    logic [11:0]   snap [9];
    logic [AW-1:0] acc [9];
    logic [11:0]   last [9];
    logic [3:0]    ch;
    logic          primed;
    logic [11:0]   xReg;
    logic [AW-1:0] accReg;
    logic [AW:0]   accSum;
    logic [AW-1:0] accNew;
    logic [11:0]   filt;
    logic          emitNeeded;
    logic          advance;
    logic          lastCh;

    assign rawIn[0] = AdcValue00;
    assign rawIn[1] = AdcValue01;
    assign rawIn[2] = AdcValue02;
    assign rawIn[3] = AdcValue03;
    assign rawIn[4] = AdcValue04;
    assign rawIn[5] = AdcValue05;
    assign rawIn[6] = AdcValue06;
    assign rawIn[7] = AdcValue07;
    assign rawIn[8] = AdcValue08;

    // One extra bit covers acc + x before the decay term is removed; the result always fits AW bits.
    assign accSum = (AW+1)'(accReg) - (AW+1)'(accReg >> SHIFT) + (AW+1)'(xReg);
    assign accNew = primed ? accSum[AW-1:0] : (AW'(xReg) << SHIFT);
    assign filt   = accReg[AW-1:SHIFT];
    assign lastCh = (ch == 4'd8);

`ifdef ADC_SMOOTH_HYST_EN
    logic [11:0] diff;
    assign diff       = (filt >= last[ch]) ? (filt - last[ch]) : (last[ch] - filt);
    assign emitNeeded = !primed || (int'(diff) >= DEADBAND);
`else
    assign emitNeeded = !primed || (filt != last[ch]);
`endif

    always_comb begin
        stateNext = state;
        advance   = 1'b0;
        case (state)
            IDLE:    if (Tick) stateNext = LOAD;
            LOAD:    stateNext = FILTER;
            FILTER:  stateNext = COMPARE;
            COMPARE: begin
                if (emitNeeded) begin
                    stateNext = EMIT;
                end else begin
                    advance   = 1'b1;
                    stateNext = lastCh ? IDLE : LOAD;
                end
            end
            EMIT: begin
                if (eventBus.EventReady) begin
                    advance   = 1'b1;
                    stateNext = lastCh ? IDLE : LOAD;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock_qsys) begin
        if (Reset) begin
            state                 <= IDLE;
            ch                    <= 4'd0;
            primed                <= 1'b0;
            Overrun               <= 1'b0;
            xReg                  <= '0;
            accReg                <= '0;
            eventBus.EventChannel <= 4'd0;
            eventBus.EventValue   <= 12'd0;
            for (int i = 0; i < 9; i++) begin
                snap[i] <= '0;
                acc[i]  <= '0;
                last[i] <= '0;
            end
        end else begin
            state <= stateNext;
            if (Tick && state == IDLE) begin
                for (int i = 0; i < 9; i++) snap[i] <= rawIn[i];
                ch <= 4'd0;
            end
            if (Tick && state != IDLE) Overrun <= 1'b1;
            if (state == LOAD) begin
                xReg   <= snap[ch];
                accReg <= acc[ch];
            end
            if (state == FILTER) begin
                acc[ch] <= accNew;
                accReg  <= accNew;
            end
            if (state == COMPARE && emitNeeded) begin
                eventBus.EventChannel <= ch;
                eventBus.EventValue   <= filt;
            end
            if (state == EMIT && eventBus.EventReady) last[ch] <= filt;
            if (advance) begin
                if (lastCh) begin
                    primed <= 1'b1;
                    ch     <= 4'd0;
                end else begin
                    ch <= ch + 4'd1;
                end
            end
        end
    end

    assign eventBus.EventValid = (state == EMIT);
    assign Busy                = (state != IDLE);
    assign DebugState          = state;
endmodule
